seg_scan_ctrl: RTL and testbench

Memory-mapped 8-digit seven-segment scan controller for the MiniSys1A IO interface. Holds the 32-bit display value plus digit-enable and decimal-point masks written by the CPU. Time-multiplexes the digits by generating a 3-bit digit index that drives the downstream 3-to-8 active-low digit-select decoder. Produces the matching active-low segment pattern for the selected digit.

---
 rtl/seg_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Memory-mapped 8-digit seven-segment scan controller with CPU-writable value, enable and dp masks.
// Optional feature: define SEG_LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 7 always shown).
module seg_scan_ctrl #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [2:0]  digit_idx,
  output logic [7:0]  seg
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);
`ifdef SEG_LEAD_ZERO_BLANK_EN
  localparam logic [7:0] SEG_RST = 8'hFF;
`else
  localparam logic [7:0] SEG_RST = 8'hC0;
`endif

  logic [31:0]   data_q, data_d;
  logic [7:0]    en_q, en_d;
  logic [7:0]    dp_q, dp_d;
  logic [CW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [7:0]    seg_q, seg_d;
  logic          tick_s;
  logic [2:0]    nidx_s;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
      4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
      4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'hA: r = 7'h08;  4'hB: r = 7'h03;
      4'hC: r = 7'h46;  4'hD: r = 7'h21;  4'hE: r = 7'h06;  4'hF: r = 7'h0E;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] encode(input logic [2:0] i, input logic [31:0] d,
                                        input logic [7:0] en, input logic [7:0] dp);
    logic [4:0] base;
    logic [3:0] nib;
    logic       blank;
    logic [7:0] r;
    base  = 5'd31 - {i, 2'b00};
    nib   = d[base -: 4];
    blank = 1'b0;
`ifdef SEG_LEAD_ZERO_BLANK_EN
    // Leading-zero run: every nibble from digit 0 through digit i must be zero.
    blank = (i != 3'd7);
    for (int j = 0; j < 8; j++) begin
      if (3'(j) <= i) begin
        blank = blank & (d[31-4*j -: 4] == 4'h0);
      end else begin
        blank = blank;
      end
    end
`endif
    if (!en[i] || blank) begin
      r = 8'hFF;
    end else begin
      r = {~dp[i], hex7(nib)};
    end
    return r;
  endfunction

  assign tick_s = (div_q == DIV_MAX);
  assign nidx_s = tick_s ? (idx_q + 3'd1) : idx_q;

  // Next-state for the divider, digit index, segment pattern, registers and read data.
  always_comb begin
    div_d   = tick_s ? '0 : (div_q + CW'(1));
    idx_d   = nidx_s;
    seg_d   = encode(nidx_s, data_q, en_q, dp_q);
    data_d  = data_q;
    en_d    = en_q;
    dp_d    = dp_q;
    rdata_d = rdata_q;
    if (cs && we) begin
      case (addr)
        2'd0:    data_d[15:0]  = wdata;
        2'd1:    data_d[31:16] = wdata;
        2'd2:    en_d          = wdata[7:0];
        2'd3:    dp_d          = wdata[7:0];
        default: data_d        = data_q;
      endcase
    end else if (cs) begin
      case (addr)
        2'd0:    rdata_d = data_q[15:0];
        2'd1:    rdata_d = data_q[31:16];
        2'd2:    rdata_d = {8'h00, en_q};
        2'd3:    rdata_d = {8'h00, dp_q};
        default: rdata_d = rdata_q;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 32'h0000_0000;
      en_q    <= 8'hFF;
      dp_q    <= 8'h00;
      div_q   <= '0;
      idx_q   <= 3'd0;
      rdata_q <= 16'h0000;
      seg_q   <= SEG_RST;
    end else begin
      data_q  <= data_d;
      en_q    <= en_d;
      dp_q    <= dp_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      seg_q   <= seg_d;
    end
  end

  assign rdata     = rdata_q;
  assign digit_idx = idx_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-level reference model predicts digit index,
// segments and read data after each edge; a monitor pops and compares after every edge.
module tb_seg_scan_ctrl;

  localparam int CD = 4;
`ifdef SEG_LEAD_ZERO_BLANK_EN
  localparam logic [7:0] SEG_RST = 8'hFF;
`else
  localparam logic [7:0] SEG_RST = 8'hC0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic [2:0]  digit_idx;
  logic [7:0]  seg;

  seg_scan_ctrl #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .digit_idx(digit_idx), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  idx;
    logic [7:0]  seg;
    logic [15:0] rd;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] m_data;
  logic [7:0]  m_en, m_dp;
  logic [15:0] m_rd;
  int          k;
  logic [6:0]  hex_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [7:0] m_enc(int i);
    int sh;
    int nib;
    bit blank;
    sh = 28 - 4 * i;
    nib = int'((m_data >> sh) & 32'hF);
    blank = 1'b0;
`ifdef SEG_LEAD_ZERO_BLANK_EN
    if (i < 7 && (m_data >> sh) == 32'h0) blank = 1'b1;
`endif
    if (m_en[i] == 1'b0 || blank) return 8'hFF;
    return {~m_dp[i], hex_tab[nib]};
  endfunction

  task automatic model_reset();
    m_data = 32'h0; m_en = 8'hFF; m_dp = 8'h00; m_rd = 16'h0; k = 0;
  endtask

  task automatic check(string name, logic [15:0] act, logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One bus cycle: drive inputs, predict the post-edge outputs, then apply the write.
  task automatic step(bit c, bit w, logic [1:0] a, logic [15:0] d);
    exp_t e;
    int di;
    @(negedge clk);
    cs = c; we = w; addr = a; wdata = d;
    k++;
    di = (k / CD) % 8;
    e.idx = 3'(di);
    e.seg = m_enc(di);
    if (c && !w) begin
      case (a)
        2'd0: m_rd = m_data[15:0];
        2'd1: m_rd = m_data[31:16];
        2'd2: m_rd = {8'h00, m_en};
        default: m_rd = {8'h00, m_dp};
      endcase
    end
    e.rd = m_rd;
    sb.push_back(e);
    if (c && w) begin
      case (a)
        2'd0: m_data[15:0] = d;
        2'd1: m_data[31:16] = d;
        2'd2: m_en = d[7:0];
        default: m_dp = d[7:0];
      endcase
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_idx", {13'h0, digit_idx}, 16'h0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_seg", {8'h0, seg}, {8'h0, SEG_RST});
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
  endtask

  // Monitor: after every edge, compare the DUT against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("digit_idx", {13'h0, digit_idx}, {13'h0, e.idx});
        check("seg", {8'h0, seg}, {8'h0, e.seg});
        check("rdata", rdata, e.rd);
      end
    end
  end

  initial begin
    model_reset();
    do_reset();
    idle(40);
    // Display value
    step(1'b1, 1'b1, 2'd1, 16'h1234);
    step(1'b1, 1'b1, 2'd0, 16'hABCD);
    idle(40);
    // Masks with zero data
    step(1'b1, 1'b1, 2'd2, 16'h00F0);
    step(1'b1, 1'b1, 2'd3, 16'h0081);
    step(1'b1, 1'b1, 2'd0, 16'h0000);
    step(1'b1, 1'b1, 2'd1, 16'h0000);
    idle(36);
    // Blanking patterns (plain hex without the macro)
    step(1'b1, 1'b1, 2'd2, 16'h00FF);
    step(1'b1, 1'b1, 2'd3, 16'h0000);
    step(1'b1, 1'b1, 2'd0, 16'h0120);
    idle(36);
    step(1'b1, 1'b1, 2'd0, 16'h0000);
    idle(36);
    // Write lands on the same edge that selects digit 7
    step(1'b1, 1'b1, 2'd1, 16'h1234);
    step(1'b1, 1'b1, 2'd0, 16'hABC9);
    while ((k % (8 * CD)) != (7 * CD - 1)) step(1'b0, 1'b0, 2'd0, 16'h0);
    step(1'b1, 1'b1, 2'd0, 16'h5555);
    idle(10);
    // Read-back of every address
    step(1'b1, 1'b1, 2'd0, 16'hBEEF);
    step(1'b1, 1'b1, 2'd1, 16'hCAFE);
    step(1'b1, 1'b1, 2'd2, 16'hFF5A);
    step(1'b1, 1'b1, 2'd3, 16'h12A5);
    for (int a = 0; a < 4; a++) step(1'b1, 1'b0, 2'(a), 16'h0);
    idle(3);
    // Mid-frame reset, then randomized traffic
    idle(13);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 16'($urandom));
    end
    idle(2);
    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 16'(sb.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
